// File: rtl/red571_pkg.sv
// Shared constants, FSM state type and fold-count helper for the GF(2^571) reducer.
package red571_pkg;

    localparam int unsigned M        = 571;
    localparam int unsigned AW       = 2 * M;
    localparam int unsigned HW       = 11;
    localparam int unsigned NUM_TAPS = 4;
    localparam int unsigned TAP_OFS [NUM_TAPS] = '{0, 2, 5, 10};

    typedef enum logic [1:0] {
        StIdle,
        StFold,
        StDone
    } state_e;

    function automatic int unsigned calc_folds(input int unsigned digit);
        return (M + digit - 1) / digit;
    endfunction

endpackage

// File: rtl/red571_fold.sv
// One fold step: takes the window acc[hi:lo], clears it and XORs it back in at the
// pentanomial tap offsets relative to lo-571.
module red571_fold
    import red571_pkg::*;
#(
    parameter int unsigned DIGIT = 64
) (
    input  logic [AW-1:0] acc_i,
    input  logic [HW-1:0] hi_i,
    output logic [AW-1:0] acc_o,
    output logic [HW-1:0] hi_o
);

    logic [HW-1:0]    lo;
    logic [HW-1:0]    len;
    logic [DIGIT-1:0] wmask;
    logic [DIGIT-1:0] w;
    logic [AW-1:0]    w_ext;
    logic [AW-1:0]    acc_n;

    always_comb begin
        if (hi_i >= HW'(M + DIGIT - 1)) begin
            lo = hi_i - HW'(DIGIT - 1);
        end else begin
            lo = HW'(M);
        end
        len   = hi_i - lo + HW'(1);
        // A full-width shift yields zero, so a full window gets an all-ones mask.
        wmask = ~({DIGIT{1'b1}} << len);
        w     = DIGIT'(acc_i >> lo) & wmask;
        w_ext = AW'(w);
        acc_n = acc_i & ~(AW'(wmask) << lo);
        for (int t = 0; t < NUM_TAPS; t++) begin
            acc_n = acc_n ^ (w_ext << (lo - HW'(M) + HW'(TAP_OFS[t])));
        end
        acc_o = acc_n;
        hi_o  = lo - HW'(1);
    end

endmodule

// File: rtl/red571_reducer.sv
// Iterative reducer of a 1142-bit GF(2) product modulo x^571+x^10+x^5+x^2+1.
// Define RED571_ZERO_SKIP_EN to skip folding when the upper half of the input is zero.
module red571_reducer
    import red571_pkg::*;
#(
    parameter int unsigned DIGIT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1141:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [570:0]  out_data
);

    localparam int unsigned N       = calc_folds(DIGIT);
    localparam int unsigned CW      = $clog2(N) + 1;
    localparam logic [HW-1:0] HI_INIT = HW'(AW - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [HW-1:0] hi_q, hi_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] fold_acc;
    logic [HW-1:0] fold_hi;

    red571_fold #(
        .DIGIT (DIGIT)
    ) u_fold (
        .acc_i (acc_q),
        .hi_i  (hi_q),
        .acc_o (fold_acc),
        .hi_o  (fold_hi)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            hi_q    <= HI_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    acc_d = in_data;
                    hi_d  = HI_INIT;
                    cnt_d = '0;
`ifdef RED571_ZERO_SKIP_EN
                    state_d = (in_data[AW-1:M] == '0) ? StDone : StFold;
`else
                    state_d = StFold;
`endif
                end
            end
            StFold: begin
                acc_d = fold_acc;
                hi_d  = fold_hi;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                    hi_d    = HI_INIT;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        out_data  = out_valid ? acc_q[M-1:0] : '0;
    end

endmodule

// File: doc/red571_reducer.md
RED571_REDUCER -- requirements
Module: red571_reducer

Interface
REQ-001 SHALL provide parameter DIGIT, default 64: number of excess bits folded per cycle, legal range 8..286.
REQ-002 SHALL have port clk, input, 1: rising-edge clock.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1: in_data is valid.
REQ-005 SHALL have port in_ready, output, 1: block can accept a product.
REQ-006 SHALL have port in_data, input, 1142: GF(2) product polynomial from the 571x571 multiplier.
REQ-007 SHALL have port out_valid, output, 1: out_data holds a reduced result.
REQ-008 SHALL have port out_ready, input, 1: consumer accepts out_data.
REQ-009 SHALL have port out_data, output, 571: in_data mod f(x), where f(x)=x^571+x^10+x^5+x^2+1.

Function
REQ-010 SHALL use a three-state FSM: IDLE, FOLD, DONE.
REQ-011 SHALL drive in_ready=1 only in IDLE; all arithmetic is XOR (carry-free).
REQ-012 SHALL, on an edge with in_valid&in_ready, load the 1142-bit accumulator with in_data, set hi=1141 and enter FOLD.
REQ-013 SHALL, in each FOLD cycle, take window W = acc[hi:lo] with lo=max(571,hi-DIGIT+1), clear those bits, XOR W into acc at offsets (lo-571)+{0,2,5,10}, then set hi=lo-1.
REQ-014 SHALL run exactly N=ceil(571/DIGIT) FOLD cycles (N=9 at DIGIT=64), then enter DONE.
REQ-015 SHALL drive out_data=acc[570:0] and out_valid=1 while in DONE; out_data SHALL remain stable until the handshake.
REQ-016 SHALL, on an edge with out_valid&out_ready, return to IDLE; no new input is accepted on that same edge.
REQ-017 SHALL raise out_valid in the cycle after edge k+N when the accepting edge is k; throughput is one result per N+2 cycles.
REQ-018 SHALL ignore in_valid outside IDLE and hold in_data sampling to the accepting edge only.
REQ-019 SHALL fold bit 1141 like any other excess bit; no input bit is discarded.

Reset
REQ-020 SHALL, on rst, set state=IDLE, acc=0, hi=1141, out_valid=0, out_data=0, in_ready=1 on the following cycle.
REQ-021 SHALL, on rst mid-FOLD or in DONE, abort the operation and drop the pending result.

Configuration
REQ-022 SHALL, with RED571_ZERO_SKIP_EN defined, bypass FOLD and go directly to DONE when an accepted in_data[1141:571]==0, giving out_valid in the cycle after the accepting edge.
REQ-023 SHALL, without RED571_ZERO_SKIP_EN, always execute all N FOLD cycles regardless of the input value.

Structure
REQ-024 SHALL place in shared package red571_pkg: M=571, the tap offsets {0,2,5,10}, the FSM state enum, and a constant function computing N from DIGIT.
REQ-025 SHALL implement the single-window fold of REQ-013 in sub-module red571_fold (combinational: acc, hi -> next acc, next hi); red571_reducer holds the FSM and registers.

Verification
REQ-026 SHALL cover: in_data=x^571, DIGIT=64 -> out_data=0x425 (x^10+x^5+x^2+1), out_valid in the cycle after edge k+9.
REQ-027 SHALL cover: in_data=x^1140 -> out_data=x^569+x^18+x^3+x^2+1.
REQ-028 SHALL cover: in_data=0xABCD -> out_data=0xABCD; latency of 9 cycles without RED571_ZERO_SKIP_EN, and out_valid in the cycle after the accepting edge with it.
REQ-029 SHALL cover: out_ready held low for 5 cycles in DONE -> out_data stable, in_ready=0, a single handshake, then IDLE.
REQ-030 SHALL cover: rst asserted on the 4th FOLD cycle -> out_valid=0 and in_ready=1 the next cycle; a following input reduces correctly.
REQ-031 SHALL cover: 1000 random products of random 571-bit a,b for DIGIT in {8,64,286}, each checked against a software carry-less multiply-and-mod model; all outputs must match.
